inst_fetch: RTL and testbench

Instruction-fetch stage directly downstream of the PC register. Takes the current fetch address and enable, and runs a request/ready transaction with the instruction memory, which may have variable latency. It raises a stall request to the ctrl module until the instruction returns, then loads the IF/ID pipeline register (pc and instruction) consumed by the decode stage. It honours stall and flush from ctrl, including holding returned data while decode is stalled.

---
 rtl/inst_fetch.sv | 132 +++++++++++++
 tb/tb_inst_fetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: req/rdy handshake with a variable-latency instruction
// memory, stall request to ctrl, and the IF/ID register with a hold buffer for decode stalls.
module inst_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_rdy,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              stallreq_if,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } if_id_t;

    state_t            state, state_nxt;
    logic              req_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    if_id_t            hold_q, hold_nxt;
    if_id_t            id_q, id_nxt;
    if_id_t            fetched, dpair;
    logic              deliver;
    logic              unused_stall;

    // Only the IF and ID stall bits matter here; PC stalling is handled upstream.
    assign unused_stall = ^{stall[5:3], stall[0]};
    assign fetched      = {inst_addr, inst_rdata};

    always_comb begin
        state_nxt   = state;
        req_nxt     = inst_req;
        addr_nxt    = inst_addr;
        hold_nxt    = hold_q;
        dpair       = fetched;
        deliver     = 1'b0;
        stallreq_if = 1'b0;
        case (state)
            S_IDLE: begin
                if (ce_i && !flush) begin
                    stallreq_if = 1'b1;
                    state_nxt   = S_WAIT;
                    req_nxt     = 1'b1;
                    addr_nxt    = pc_i;
                end
            end
            S_WAIT: begin
                stallreq_if = !inst_rdy;
                if (flush) begin
                    // The memory cannot be cancelled: keep requesting until it answers.
                    if (inst_rdy) begin
                        state_nxt = S_IDLE;
                        req_nxt   = 1'b0;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end else if (inst_rdy) begin
                    req_nxt = 1'b0;
                    if (stall[1]) begin
                        state_nxt = S_HOLD;
                        hold_nxt  = fetched;
                    end else begin
                        state_nxt = S_IDLE;
                        deliver   = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                dpair = hold_q;
                if (flush) begin
                    state_nxt = S_IDLE;
                    hold_nxt  = '0;
                end else if (!stall[1]) begin
                    state_nxt = S_IDLE;
                    deliver   = 1'b1;
                end
            end
            S_DRAIN: begin
                stallreq_if = 1'b1;
                if (inst_rdy) begin
                    state_nxt = S_IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    // IF/ID update: flush beats everything, then bubble/load/hold by stall bits.
    always_comb begin
        id_nxt = id_q;
        if (flush)
            id_nxt = '0;
        else if (stall[1] && !stall[2])
            id_nxt = '0;
        else if (!stall[1])
            id_nxt = deliver ? dpair : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            inst_req  <= 1'b0;
            inst_addr <= '0;
            hold_q    <= '0;
            id_q      <= '0;
        end else begin
            state     <= state_nxt;
            inst_req  <= req_nxt;
            inst_addr <= addr_nxt;
            hold_q    <= hold_nxt;
            id_q      <= id_nxt;
        end
    end

    assign id_pc   = id_q.pc;
    assign id_inst = id_q.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory/ctrl/PC models around the DUT, a transaction-level
// reference checked every cycle, plus directed literal expectations.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_rdy;
    logic [31:0] inst_rdata;
    logic        stallreq_if;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int n_chk = 0;
    int n_fail = 0;

    logic        ctrl_auto;
    logic [5:0]  stall_man;
    int          mem_lat;
    int          mem_cnt;
    logic        rdy_junk;
    logic        pc_ld;
    logic [31:0] pc_ld_val;
    logic [31:0] pc_q;
    logic        chk_en = 1'b0;

    inst_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .pc_i(pc_i), .ce_i(ce_i), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rdy(inst_rdy), .inst_rdata(inst_rdata), .stallreq_if(stallreq_if),
        .id_pc(id_pc), .id_inst(id_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = (a >> 2) + 32'd1;
        return 32'h3400_0000 | ((k & 32'hff) << 16) | (k & 32'hff);
    endfunction

    // ctrl: answers a fetch stall request with 6'b000011 unless overridden
    assign stall      = ctrl_auto ? (stallreq_if ? 6'b000011 : 6'b000000) : stall_man;
    assign inst_rdy   = inst_req ? (mem_cnt >= mem_lat) : rdy_junk;
    assign inst_rdata = mem_word(inst_addr);
    assign pc_i       = pc_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_cnt <= 0;
        else if (inst_req) mem_cnt <= inst_rdy ? 0 : mem_cnt + 1;
        else mem_cnt <= 0;
    end

    always @(posedge clk) begin
        if (pc_ld) pc_q <= pc_ld_val;
        else if (!stall[0]) pc_q <= pc_q + 32'd4;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: one outstanding transaction (possibly marked for discard) and an
    // optional held result; the IF/ID register follows the ctrl priority rules.
    logic        m_pend, m_disc, m_hold;
    logic [31:0] m_addr, m_hpc, m_hinst, m_idpc, m_idinst;

    always @(negedge clk) begin
        logic        e_sreq, dlv;
        logic [31:0] d_pc, d_inst;
        if (!rst_n) begin
            m_pend = 0; m_disc = 0; m_hold = 0;
            m_addr = 0; m_hpc = 0; m_hinst = 0; m_idpc = 0; m_idinst = 0;
        end
        if (chk_en) begin
            e_sreq = (!m_pend && !m_hold && ce_i && !flush) || (m_pend && (m_disc || !inst_rdy));
            chk("m_inst_req", {31'd0, inst_req}, {31'd0, m_pend});
            chk("m_inst_addr", inst_addr, m_addr);
            chk("m_stallreq_if", {31'd0, stallreq_if}, {31'd0, e_sreq});
            chk("m_id_pc", id_pc, m_idpc);
            chk("m_id_inst", id_inst, m_idinst);
        end
        if (rst_n) begin
            dlv    = (m_pend && !m_disc && inst_rdy) || m_hold;
            d_pc   = m_hold ? m_hpc : m_addr;
            d_inst = m_hold ? m_hinst : inst_rdata;
            if (flush || (stall[1] && !stall[2])) begin
                m_idpc = 0; m_idinst = 0;
            end else if (!stall[1]) begin
                m_idpc   = dlv ? d_pc : 32'd0;
                m_idinst = dlv ? d_inst : 32'd0;
            end
            if (m_pend) begin
                if (inst_rdy) begin
                    if (!m_disc && !flush && stall[1]) begin
                        m_hold = 1; m_hpc = m_addr; m_hinst = inst_rdata;
                    end
                    m_pend = 0; m_disc = 0;
                end else if (flush) begin
                    m_disc = 1;
                end
            end else if (m_hold) begin
                if (flush || !stall[1]) m_hold = 0;
            end else if (ce_i && !flush) begin
                m_pend = 1; m_disc = 0; m_addr = pc_i;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_id(input logic [31:0] pc, input logic [31:0] ins, input int budget);
        int n = 0;
        while (!(id_pc === pc && id_inst === ins) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_id_pc", id_pc, pc);
        chk("wait_id_inst", id_inst, ins);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ce_i = 0; flush = 0; ctrl_auto = 1; stall_man = 0; mem_lat = 0;
        rdy_junk = 0; pc_ld = 1; pc_ld_val = 0;
        #1 rst_n = 0;
        #3;
        chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_inst_addr", inst_addr, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        chk_en = 1;
        tick(); tick();
        rst_n = 1;

        // zero-wait memory, three back-to-back fetches
        pc_ld = 0; ce_i = 1;
        tick(); tick();
        chk("zw_pc0", id_pc, 32'h0);
        chk("zw_inst0", id_inst, 32'h3401_0001);
        tick();
        chk("zw_bubble", id_inst, 32'h0);
        tick();
        chk("zw_pc4", id_pc, 32'h4);
        chk("zw_inst4", id_inst, 32'h3402_0002);
        tick(); tick();
        chk("zw_pc8", id_pc, 32'h8);
        chk("zw_inst8", id_inst, 32'h3403_0003);

        // fetch disabled; stray rdy must be ignored
        ce_i = 0; rdy_junk = 1;
        repeat (5) begin
            tick(); #1;
            chk("idle_req", {31'd0, inst_req}, 32'd0);
            chk("idle_sreq", {31'd0, stallreq_if}, 32'd0);
        end
        rdy_junk = 0;

        // 3-cycle latency at 0x10, ce_i dropped mid-wait
        pc_ld = 1; pc_ld_val = 32'h10;
        tick();
        pc_ld = 0; ce_i = 1; mem_lat = 3;
        #1 chk("lat_sreq_idle", {31'd0, stallreq_if}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            ce_i = 0;
            #1;
            chk("lat_req", {31'd0, inst_req}, 32'd1);
            chk("lat_addr", inst_addr, 32'h10);
            chk("lat_sreq", {31'd0, stallreq_if}, 32'd1);
        end
        tick(); #1;
        chk("lat_rdy_req", {31'd0, inst_req}, 32'd1);
        chk("lat_rdy_sreq", {31'd0, stallreq_if}, 32'd0);
        tick();
        chk("lat_id_pc", id_pc, 32'h10);
        chk("lat_id_inst", id_inst, 32'h3405_0005);
        chk("lat_req_drop", {31'd0, inst_req}, 32'd0);

        // decode stalled in the rdy cycle at 0x20 -> hold, then release
        pc_ld = 1; pc_ld_val = 32'h20;
        tick();
        pc_ld = 0; ce_i = 1; mem_lat = 1;
        tick(); ce_i = 0;
        tick(); ctrl_auto = 0; stall_man = 6'b000111;
        tick(); #1;
        chk("hold_req", {31'd0, inst_req}, 32'd0);
        chk("hold_id_pc", id_pc, 32'h0);
        chk("hold_sreq", {31'd0, stallreq_if}, 32'd0);
        tick(); stall_man = 6'b000000;
        tick();
        chk("rel_id_pc", id_pc, 32'h20);
        chk("rel_id_inst", id_inst, 32'h3409_0009);
        ctrl_auto = 1;

        // flush while holding: buffer discarded
        pc_ld = 1; pc_ld_val = 32'h28;
        tick();
        pc_ld = 0; ce_i = 1; mem_lat = 0;
        tick(); ce_i = 0; ctrl_auto = 0; stall_man = 6'b000111;
        tick(); flush = 1;
        tick(); flush = 0; stall_man = 6'b000000; ctrl_auto = 1;
        #1 chk("hflush_id_pc", id_pc, 32'h0);
        tick(); tick();
        chk("hflush_no_load", id_pc, 32'h0);

        // flush one cycle into a wait at 0x30 -> drain, then refetch
        pc_ld = 1; pc_ld_val = 32'h30;
        tick();
        pc_ld = 0; ce_i = 1; mem_lat = 4;
        tick(); ce_i = 0;
        tick(); flush = 1;
        tick(); flush = 0; #1;
        chk("drain_req", {31'd0, inst_req}, 32'd1);
        chk("drain_addr", inst_addr, 32'h30);
        chk("drain_sreq", {31'd0, stallreq_if}, 32'd1);
        chk("drain_id_pc", id_pc, 32'h0);
        chk("drain_id_inst", id_inst, 32'h0);
        tick(); tick(); #1;
        chk("drain_rdy_sreq", {31'd0, stallreq_if}, 32'd1);
        tick();
        chk("drain_done_req", {31'd0, inst_req}, 32'd0);
        chk("drain_done_id", id_inst, 32'h0);
        ce_i = 1;
        wait_id(32'h30, 32'h340D_000D, 12);
        ce_i = 0;

        // flush together with rdy: data dropped
        pc_ld = 1; pc_ld_val = 32'h50;
        tick();
        pc_ld = 0; ce_i = 1; mem_lat = 0;
        tick(); flush = 1; ce_i = 0;
        tick(); flush = 0; #1;
        chk("frdy_req", {31'd0, inst_req}, 32'd0);
        chk("frdy_id_pc", id_pc, 32'h0);
        chk("frdy_id_inst", id_inst, 32'h0);

        // asynchronous reset in the middle of a wait
        pc_ld = 1; pc_ld_val = 32'h60;
        tick();
        pc_ld = 0; ce_i = 1; mem_lat = 0;
        tick();
        tick(); ctrl_auto = 0; stall_man = 6'b000111; mem_lat = 5;
        #1 chk("pre_rst_id_pc", id_pc, 32'h60);
        tick(); #1;
        chk("pre_rst_req", {31'd0, inst_req}, 32'd1);
        chk("pre_rst_id_inst", id_inst, 32'h3419_0019);
        rst_n = 0; pc_ld = 1; pc_ld_val = 32'h80;
        #1;
        chk("async_rst_req", {31'd0, inst_req}, 32'd0);
        chk("async_rst_addr", inst_addr, 32'h0);
        chk("async_rst_id_pc", id_pc, 32'h0);
        chk("async_rst_id_inst", id_inst, 32'h0);
        tick();
        rst_n = 1; pc_ld = 0; ctrl_auto = 1;
        tick();
        chk("post_rst_req", {31'd0, inst_req}, 32'd1);
        chk("post_rst_addr", inst_addr, 32'h80);
        wait_id(32'h80, 32'h3421_0021, 12);
        ce_i = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
